// File: rtl/gb_mmio_pkg.sv
// Shared MMIO constants, OAM DMA state encoding and the DMA source-page remap.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gb_mmio_pkg;

    localparam logic [15:0] ADDR_DMA_REG  = 16'hFF46;
    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam logic [15:0] BUS_IDLE_ADDR = 16'hFFFF;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_DELAY,
        DMA_XFER
    } dma_state_t;

    // Pages FE/FF would source from OAM/IO; the DMA reads the work-RAM shadow at DE/DF instead.
    function automatic logic [7:0] remap_src(input logic [7:0] hi);
        return (hi >= 8'hFE) ? (hi - 8'h20) : hi;
    endfunction

endpackage

// File: rtl/dma_slot_timer.sv
// Byte-slot sequencer: phase counter inside a slot plus byte index, with decoded slot strobes.
// Latency: strobes are decoded from registered counters; counters clear the cycle after run_i drops.
// Backpressure: none; the slot cadence is fixed while run_i is high.
module dma_slot_timer #(
    parameter int BYTE_CYCLES = 4,
    parameter int READ_LAT    = 1,
    parameter int N_BYTES     = 160
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    output logic [7:0] idx_o,
    output logic       rd_phase_o,
    output logic       latch_stb_o,
    output logic       wr_stb_o,
    output logic       last_byte_o
);

    localparam int PW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [PW-1:0] PH_LATCH = PW'(READ_LAT);
    localparam logic [PW-1:0] PH_WR    = PW'(READ_LAT + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(BYTE_CYCLES - 1);
    localparam logic [7:0]    IDX_LAST = 8'(N_BYTES - 1);

    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    idx_q, idx_d;

    assign idx_o       = idx_q;
    assign rd_phase_o  = (phase_q <= PH_LATCH);
    assign latch_stb_o = run_i && (phase_q == PH_LATCH);
    assign wr_stb_o    = run_i && (phase_q == PH_WR);
    assign last_byte_o = run_i && (phase_q == PH_LAST) && (idx_q == IDX_LAST);

    // Next-state: hold at zero while stopped, otherwise step phase and roll idx at slot end.
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        if (!run_i) begin
            phase_d = '0;
            idx_d   = '0;
        end else if (phase_q == PH_LAST) begin
            phase_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? 8'h00 : (idx_q + 8'h01);
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/oam_dma_engine.sv
// OAM DMA: a write to FF46 copies 160 bytes from page XX into FE00-FE9F over the MMU master port.
// Latency: first source read START_DELAY clocks after trigger, one byte per BYTE_CYCLES clocks.
// Backpressure: none; the MMU master port is assumed to accept every cycle, retrigger restarts.
module oam_dma_engine #(
    parameter int START_DELAY = 4,
    parameter int BYTE_CYCLES = 4,
    parameter int READ_LAT    = 1,
    parameter int N_BYTES     = 160
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] mmio_addr_i,
    input  logic [7:0]  mmio_write_value_i,
    input  logic        mmio_write_enable_i,
    output logic [7:0]  mmio_read_out_o,
    output logic [15:0] dma_addr_o,
    output logic [7:0]  dma_write_value_o,
    output logic        dma_write_enable_o,
    input  logic [7:0]  dma_read_out_i,
    output logic        dma_active_o
);
    import gb_mmio_pkg::*;

    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(START_DELAY - 1);

    dma_state_t  state_q;
    logic [DW-1:0] cnt_q;
    logic [7:0]  src_hi_q;
    logic [7:0]  data_q;
    logic [7:0]  rd_q;
    logic        hit_prev_q;
    logic        active_q;

    logic        reg_hit;
    logic        trig;
    logic        run;
    logic [7:0]  idx;
    logic        rd_phase;
    logic        latch_stb;
    logic        wr_stb;
    logic        last_byte;

    // A held write_enable is one trigger: fire only on the rising edge of the register hit.
    assign reg_hit = mmio_write_enable_i && (mmio_addr_i == ADDR_DMA_REG);
    assign trig    = reg_hit && !hit_prev_q;
    assign run     = (state_q == DMA_XFER);

    assign mmio_read_out_o = rd_q;
    assign dma_active_o    = active_q;

    dma_slot_timer #(
        .BYTE_CYCLES (BYTE_CYCLES),
        .READ_LAT    (READ_LAT),
        .N_BYTES     (N_BYTES)
    ) u_slot_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .run_i       (run),
        .idx_o       (idx),
        .rd_phase_o  (rd_phase),
        .latch_stb_o (latch_stb),
        .wr_stb_o    (wr_stb),
        .last_byte_o (last_byte)
    );

    // Register-port edge detector and registered FF46 readback.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_prev_q <= 1'b0;
            rd_q       <= 8'hFF;
        end else begin
            hit_prev_q <= reg_hit;
            rd_q       <= (mmio_addr_i == ADDR_DMA_REG) ? src_hi_q : 8'hFF;
        end
    end

    // Transfer FSM; a trigger in any state reloads the source page and restarts the start delay.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= DMA_IDLE;
            cnt_q    <= '0;
            src_hi_q <= 8'hFF;
            data_q   <= 8'h00;
            active_q <= 1'b0;
        end else begin
            if (run && latch_stb) begin
                data_q <= dma_read_out_i;
            end
            if (trig) begin
                src_hi_q <= mmio_write_value_i;
                state_q  <= DMA_DELAY;
                cnt_q    <= '0;
                active_q <= 1'b1;
            end else begin
                case (state_q)
                    DMA_IDLE: begin
                        active_q <= 1'b0;
                    end
                    DMA_DELAY: begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= DMA_XFER;
                        end else begin
                            cnt_q <= cnt_q + DW'(1);
                        end
                    end
                    DMA_XFER: begin
                        if (last_byte) begin
                            state_q  <= DMA_IDLE;
                            active_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= DMA_IDLE;
                        active_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Bus mux: idle address outside XFER so the CPU keeps OAM; source read then OAM write per slot.
    always_comb begin
        dma_addr_o         = BUS_IDLE_ADDR;
        dma_write_value_o  = 8'h00;
        dma_write_enable_o = 1'b0;
        if (run) begin
            if (rd_phase) begin
                dma_addr_o = {remap_src(src_hi_q), idx};
            end else begin
                dma_addr_o = OAM_BASE + {8'h00, idx};
            end
            if (wr_stb) begin
                dma_write_enable_o = 1'b1;
                dma_write_value_o  = data_q;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine with a cycle-level reference model and literal anchors.
// Latency: n/a.
// Backpressure: n/a.
module tb_oam_dma_engine;

    localparam int SD = 4;
    localparam int BC = 4;
    localparam int RL = 1;
    localparam int NB = 160;
    localparam int TOTAL = SD + NB * BC;

    logic        clk;
    logic        rst_n;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_wv;
    logic        mmio_we;
    logic [7:0]  mmio_rd;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wv;
    logic        dma_we;
    logic [7:0]  mem_rd;
    logic        dma_active;

    int errors = 0;
    int checks = 0;

    oam_dma_engine #(
        .START_DELAY (SD),
        .BYTE_CYCLES (BC),
        .READ_LAT    (RL),
        .N_BYTES     (NB)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .mmio_addr_i         (mmio_addr),
        .mmio_write_value_i  (mmio_wv),
        .mmio_write_enable_i (mmio_we),
        .mmio_read_out_o     (mmio_rd),
        .dma_addr_o          (dma_addr),
        .dma_write_value_o   (dma_wv),
        .dma_write_enable_o  (dma_we),
        .dma_read_out_i      (mem_rd),
        .dma_active_o        (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] map_src(input logic [7:0] s);
        return (s == 8'hFE || s == 8'hFF) ? (s - 8'h20) : s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory behind the MMU: one-cycle registered read of a fixed pattern.
    always @(posedge clk) mem_rd <= pat(dma_addr);

    // OAM image and write-strobe count.
    logic [7:0] oam [0:NB-1];
    int strobes = 0;
    always @(posedge clk) begin
        if (rst_n && dma_we) begin
            strobes++;
            if (dma_addr >= 16'hFE00 && dma_addr < 16'hFE00 + 16'(NB))
                oam[dma_addr - 16'hFE00] = dma_wv;
        end
    end

    // Reference model state and observations used by literal checks.
    int         cyc = 0;
    int         m_t = 0;
    logic       m_act = 1'b0;
    logic       m_prev = 1'b0;
    logic [7:0] m_src = 8'hFF;
    logic [7:0] exp_rd;
    logic       tr;
    int         c, s, k, ph;
    logic [15:0] ea;
    logic        ewe;
    logic [7:0]  ewv, mh;
    int          obs_we_e = -1, obs_fall_e = -1, obs_rd_e = -1;
    logic [7:0]  obs_wv;
    logic [15:0] obs_we_addr, obs_rd_addr;
    logic        obs_prev_act = 1'b0;

    // Model: trigger is a rising edge of a FF46 write; then fixed slot arithmetic from trigger time.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_act  = 1'b0;
            m_prev = 1'b0;
            m_src  = 8'hFF;
            exp_rd = 8'hFF;
        end else begin
            exp_rd = (mmio_addr == 16'hFF46) ? m_src : 8'hFF;
            tr     = mmio_we && (mmio_addr == 16'hFF46) && !m_prev;
            m_prev = mmio_we && (mmio_addr == 16'hFF46);
            if (tr) begin
                m_src = mmio_wv;
                m_t   = cyc;
                m_act = 1'b1;
            end
        end
        c = cyc - m_t;
        if (m_act && c >= TOTAL) m_act = 1'b0;
        ea = 16'hFFFF; ewe = 1'b0; ewv = 8'h00;
        if (m_act && c >= SD) begin
            s  = c - SD;
            k  = s / BC;
            ph = s % BC;
            mh = map_src(m_src);
            ea  = (ph <= RL) ? {mh, 8'(k)} : (16'hFE00 + 16'(k));
            ewe = (ph == RL + 1);
            ewv = pat({mh, 8'(k)});
        end
        #1;
        check("dma_addr", 32'(dma_addr), 32'(ea));
        check("dma_we", 32'(dma_we), 32'(ewe));
        check("dma_active", 32'(dma_active), 32'(m_act));
        check("ff46_read", 32'(mmio_rd), 32'(exp_rd));
        if (ewe) check("dma_wv", 32'(dma_wv), 32'(ewv));
        if (dma_we && obs_we_e < 0) begin
            obs_we_e = cyc; obs_wv = dma_wv; obs_we_addr = dma_addr;
        end
        if (dma_addr != 16'hFFFF && obs_rd_e < 0) begin
            obs_rd_e = cyc; obs_rd_addr = dma_addr;
        end
        if (obs_prev_act && !dma_active && obs_fall_e < 0) obs_fall_e = cyc;
        obs_prev_act = dma_active;
    end

    task automatic clear_obs();
        obs_we_e = -1; obs_fall_e = -1; obs_rd_e = -1;
        strobes = 0;
    endtask

    // Hold a FF46 write for n clocks starting at the next rising edge.
    task automatic cpu_write(input logic [7:0] v, input int n);
        @(negedge clk);
        mmio_addr = 16'hFF46; mmio_wv = v; mmio_we = 1'b1;
        repeat (n) @(negedge clk);
        mmio_addr = 16'h0000; mmio_wv = 8'h00; mmio_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mmio_addr = 16'h0000; mmio_wv = 8'h00; mmio_we = 1'b0;
        for (int i = 0; i < NB; i++) oam[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: idle after reset, FF46 reads back FF
        mmio_addr = 16'hFF46;
        @(negedge clk);
        check("rst_ff46", 32'(mmio_rd), 32'h000000FF);
        check("rst_addr", 32'(dma_addr), 32'h0000FFFF);
        check("rst_we", 32'(dma_we), 32'h0);
        check("rst_active", 32'(dma_active), 32'h0);
        mmio_addr = 16'h0000;

        // 2: full transfer from C100
        clear_obs();
        cpu_write(8'hC1, 1);
        repeat (TOTAL + 6) @(negedge clk);
        check("t2_strobes", 32'(strobes), 32'd160);
        check("t2_first_we_delay", 32'(obs_we_e - m_t), 32'd6);
        check("t2_active_drop", 32'(obs_fall_e - m_t), 32'd644);
        check("t2_first_wv", 32'(obs_wv), 32'h9B);
        check("t2_first_addr", 32'(obs_we_addr), 32'hFE00);
        check("t2_oam_last", 32'(oam[159]), 32'h04);

        // 3: FE page remapped to DE, register reads back raw FE
        clear_obs();
        cpu_write(8'hFE, 1);
        repeat (TOTAL + 6) @(negedge clk);
        check("t3_first_rd", 32'(obs_rd_addr), 32'hDE00);
        check("t3_first_wv", 32'(obs_wv), 32'h84);
        check("t3_strobes", 32'(strobes), 32'd160);
        mmio_addr = 16'hFF46;
        @(negedge clk);
        check("t3_ff46", 32'(mmio_rd), 32'hFE);
        mmio_addr = 16'h0000;

        // 4: restart at byte 50 with D0
        clear_obs();
        cpu_write(8'hC0, 1);
        repeat (SD + 50 * BC) @(negedge clk);
        strobes = 0;
        mmio_addr = 16'hFF46; mmio_wv = 8'hD0; mmio_we = 1'b1;
        @(negedge clk);
        mmio_addr = 16'h0000; mmio_wv = 8'h00; mmio_we = 1'b0;
        repeat (TOTAL + 6) @(negedge clk);
        check("t4_strobes", 32'(strobes), 32'd160);
        for (int i = 0; i < NB; i++) check("t4_oam", 32'(oam[i]), 32'(pat(16'hD000 + 16'(i))));
        check("t4_oam50", 32'(oam[50]), 32'hB8);

        // 5: write_enable held three clocks triggers once
        clear_obs();
        cpu_write(8'h33, 3);
        repeat (TOTAL + 16) @(negedge clk);
        check("t5_strobes", 32'(strobes), 32'd160);

        // 6: async reset at byte 80
        clear_obs();
        cpu_write(8'hC2, 1);
        repeat (SD + 80 * BC) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_addr", 32'(dma_addr), 32'h0000FFFF);
        check("t6_we", 32'(dma_we), 32'h0);
        check("t6_active", 32'(dma_active), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobes = 0;
        repeat (TOTAL + 50) @(negedge clk);
        check("t6_no_strobes", 32'(strobes), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
